// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Shared definitions for the registered 1-to-2 demultiplexer.
//   - cmd_e        : steering command encodings carried on i_cmd
//   - slot_state_e : one-entry output slot occupancy
//   - LO / HI      : branch indices into o_valid / i_ready / o_data_bus
// -----------------------------------------------------------------------------
package demux_pkg;

    typedef enum logic [1:0] {
        CMD_SINK  = 2'b00,
        CMD_LOW   = 2'b01,
        CMD_HIGH  = 2'b10,
        CMD_MCAST = 2'b11
    } cmd_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam int unsigned LO = 0;
    localparam int unsigned HI = 1;

endpackage

// File: rtl/demux_out_slot.sv
// -----------------------------------------------------------------------------
// demux_out_slot
//   One-entry output register with valid/ready handshake. Loads when the
//   parent steers a word here, drains on valid & ready, and supports drain
//   plus reload in the same cycle for full throughput. Data reads as zero
//   whenever the slot is empty.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : write load_data into the slot this cycle (only when free)
//   load_data   : word to store
//   ready       : downstream ready
//   valid       : slot holds a word
//   data        : stored word (zero when empty)
//   free        : slot can accept a load this cycle (empty or draining)
// -----------------------------------------------------------------------------
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  free
);

    slot_state_e           state_q;
    slot_state_e           state_d;
    logic [DATA_WIDTH-1:0] data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data    <= '0;
        end else begin
            state_q <= state_d;
            data    <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data;
        if (load) begin
            // Covers both EMPTY->FULL and FULL drain+reload.
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if (state_q == SLOT_FULL && ready) begin
            state_d = SLOT_EMPTY;
            data_d  = '0;
        end
    end

    assign valid = (state_q == SLOT_FULL);
    assign free  = ~valid | ready;

endmodule

// File: rtl/demux_1x2_reg.sv
// -----------------------------------------------------------------------------
// demux_1x2_reg
//   Registered 1-to-2 demultiplexer. Steers an accepted input word to the low
//   branch, high branch, both (multicast, all-or-nothing) or neither (sink),
//   according to i_cmd. Each branch is a one-entry slot with backpressure.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_valid     : input word valid
//   i_data_bus  : input word
//   o_ready     : input accepted when i_valid & o_ready
//   i_en        : enable; 0 stalls the input side only
//   i_cmd       : 00 sink, 01 low, 10 high, 11 multicast
//   o_valid     : [0] low valid, [1] high valid
//   o_data_bus  : low word in bits [DATA_WIDTH-1:0], high word above it
//   i_ready     : downstream ready per branch
//   o_drop_cnt  : saturating count of accepted sink words
//                 (present only with DEMUX_1X2_DROP_CNT_EN defined)
// Configuration macro: DEMUX_1X2_DROP_CNT_EN
// -----------------------------------------------------------------------------
module demux_1x2_reg
    import demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned COMMMAND_WIDTH = 2
`ifdef DEMUX_1X2_DROP_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH      = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    input  logic [DATA_WIDTH-1:0]     i_data_bus,
    output logic                      o_ready,
    input  logic                      i_en,
    input  logic [COMMMAND_WIDTH-1:0] i_cmd,
    output logic [1:0]                o_valid,
    output logic [2*DATA_WIDTH-1:0]   o_data_bus,
    input  logic [1:0]                i_ready
`ifdef DEMUX_1X2_DROP_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      o_drop_cnt
`endif
);

    cmd_e       cmd;
    logic [1:0] slot_free;
    logic [1:0] load;
    logic       accept;

    assign cmd = cmd_e'(i_cmd);

    always_comb begin
        o_ready = 1'b0;
        if (i_en) begin
            unique case (cmd)
                CMD_SINK:  o_ready = 1'b1;
                CMD_LOW:   o_ready = slot_free[LO];
                CMD_HIGH:  o_ready = slot_free[HI];
                CMD_MCAST: o_ready = slot_free[LO] & slot_free[HI];
            endcase
        end
    end

    assign accept   = i_valid & o_ready;
    // Multicast only accepts when both slots are free, so both loads fire together.
    assign load[LO] = accept & ((cmd == CMD_LOW)  | (cmd == CMD_MCAST));
    assign load[HI] = accept & ((cmd == CMD_HIGH) | (cmd == CMD_MCAST));

    demux_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[LO]),
        .load_data (i_data_bus),
        .ready     (i_ready[LO]),
        .valid     (o_valid[LO]),
        .data      (o_data_bus[LO*DATA_WIDTH +: DATA_WIDTH]),
        .free      (slot_free[LO])
    );

    demux_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[HI]),
        .load_data (i_data_bus),
        .ready     (i_ready[HI]),
        .valid     (o_valid[HI]),
        .data      (o_data_bus[HI*DATA_WIDTH +: DATA_WIDTH]),
        .free      (slot_free[HI])
    );

`ifdef DEMUX_1X2_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_drop_cnt <= '0;
        end else if (accept && cmd == CMD_SINK && o_drop_cnt != '1) begin
            o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x2_reg.sv
module tb_demux_1x2_reg;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data_bus = '0;
    logic          o_ready;
    logic          i_en = 1'b0;
    logic [1:0]    i_cmd = 2'b00;
    logic [1:0]    o_valid;
    logic [2*DW-1:0] o_data_bus;
    logic [1:0]    i_ready = 2'b00;
`ifdef DEMUX_1X2_DROP_CNT_EN
    logic [15:0]   o_drop_cnt;
`endif

    demux_1x2_reg #(.DATA_WIDTH(DW), .COMMMAND_WIDTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .o_ready    (o_ready),
        .i_en       (i_en),
        .i_cmd      (i_cmd),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .i_ready    (i_ready)
`ifdef DEMUX_1X2_DROP_CNT_EN
        ,
        .o_drop_cnt (o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          v;
        logic          en;
        logic [1:0]    cmd;
        logic [DW-1:0] data;
        logic [1:0]    ir;
        logic          exp_rdy;   // o_ready during this cycle
        logic [1:0]    exp_vld;   // outputs after the clock edge
        logic [DW-1:0] exp_lo;
        logic [DW-1:0] exp_hi;
    } vec_t;

    vec_t tbl[14];

    // Reference model: contents of each branch as a word-or-nothing.
    logic          m_full[2];
    logic [DW-1:0] m_word[2];
    int            m_drops;

    task automatic model_clear();
        for (int b = 0; b < 2; b++) begin
            m_full[b] = 1'b0;
            m_word[b] = '0;
        end
        m_drops = 0;
    endtask

    // The command bits name the destination set; a word goes only if every
    // destination can take it this cycle (empty set: always).
    function automatic logic model_ready(input logic en, input logic [1:0] cmd, input logic [1:0] ir);
        logic ok;
        ok = en;
        for (int b = 0; b < 2; b++)
            if (cmd[b] && m_full[b] && !ir[b]) ok = 1'b0;
        return ok;
    endfunction

    task automatic model_clock(input logic acc, input logic [1:0] cmd, input logic [DW-1:0] data,
                               input logic [1:0] ir);
        for (int b = 0; b < 2; b++) begin
            if (acc && cmd[b]) begin
                m_full[b] = 1'b1;
                m_word[b] = data;
            end else if (m_full[b] && ir[b]) begin
                m_full[b] = 1'b0;
                m_word[b] = '0;
            end
        end
        if (acc && cmd == 2'b00 && m_drops < 65535) m_drops++;
    endtask

    initial begin
        logic exp_rdy;
        logic acc;

        tbl[0]  = '{1'b1, 1'b1, 2'b01, 32'hAAAA_AAAA, 2'b11, 1'b1, 2'b01, 32'hAAAA_AAAA, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 2'b00, 32'h0,         2'b11, 1'b1, 2'b00, 32'h0,         32'h0};
        tbl[2]  = '{1'b1, 1'b1, 2'b10, 32'h1111_1111, 2'b00, 1'b1, 2'b10, 32'h0,         32'h1111_1111};
        tbl[3]  = '{1'b1, 1'b1, 2'b10, 32'h2222_2222, 2'b00, 1'b0, 2'b10, 32'h0,         32'h1111_1111};
        tbl[4]  = '{1'b1, 1'b1, 2'b10, 32'h2222_2222, 2'b10, 1'b1, 2'b10, 32'h0,         32'h2222_2222};
        tbl[5]  = '{1'b0, 1'b1, 2'b01, 32'h0,         2'b00, 1'b1, 2'b10, 32'h0,         32'h2222_2222};
        tbl[6]  = '{1'b1, 1'b1, 2'b01, 32'h3333_3333, 2'b00, 1'b1, 2'b11, 32'h3333_3333, 32'h2222_2222};
        tbl[7]  = '{1'b1, 1'b1, 2'b11, 32'hFFFF_FFFF, 2'b10, 1'b0, 2'b01, 32'h3333_3333, 32'h0};
        tbl[8]  = '{1'b1, 1'b1, 2'b11, 32'hFFFF_FFFF, 2'b11, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[9]  = '{1'b1, 1'b0, 2'b01, 32'h4444_4444, 2'b01, 1'b0, 2'b10, 32'h0,         32'hFFFF_FFFF};
        tbl[10] = '{1'b1, 1'b0, 2'b00, 32'h4444_4444, 2'b10, 1'b0, 2'b00, 32'h0,         32'h0};
        tbl[11] = '{1'b1, 1'b1, 2'b00, 32'h5555_5555, 2'b00, 1'b1, 2'b00, 32'h0,         32'h0};
        tbl[12] = '{1'b1, 1'b1, 2'b00, 32'h6666_6666, 2'b00, 1'b1, 2'b00, 32'h0,         32'h0};
        tbl[13] = '{1'b1, 1'b1, 2'b00, 32'h7777_7777, 2'b11, 1'b1, 2'b00, 32'h0,         32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 64'(o_valid), 64'h0);
        check("reset_data", 64'(o_data_bus), 64'h0);
`ifdef DEMUX_1X2_DROP_CNT_EN
        check("reset_drop_cnt", 64'(o_drop_cnt), 64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            i_valid    = tbl[i].v;
            i_en       = tbl[i].en;
            i_cmd      = tbl[i].cmd;
            i_data_bus = tbl[i].data;
            i_ready    = tbl[i].ir;
            #4;
            check($sformatf("tbl%0d_ready", i), 64'(o_ready), 64'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_valid", i), 64'(o_valid), 64'(tbl[i].exp_vld));
            check($sformatf("tbl%0d_lo", i), 64'(o_data_bus[DW-1:0]), 64'(tbl[i].exp_lo));
            check($sformatf("tbl%0d_hi", i), 64'(o_data_bus[2*DW-1:DW]), 64'(tbl[i].exp_hi));
        end
`ifdef DEMUX_1X2_DROP_CNT_EN
        check("sink_drop_cnt", 64'(o_drop_cnt), 64'd3);
`endif

        // Reset asserted mid-traffic with both slots full
        i_valid = 1'b1; i_en = 1'b1; i_cmd = 2'b11; i_data_bus = 32'h1234_5678; i_ready = 2'b00;
        @(posedge clk);
        #1;
        check("pre_rst_valid", 64'(o_valid), 64'h3);
        i_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(o_valid), 64'h0);
        check("async_rst_data", 64'(o_data_bus), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        i_en = 1'b1; i_cmd = 2'b11;
        #1;
        check("post_rst_ready_en", 64'(o_ready), 64'h1);
        i_en = 1'b0;
        #1;
        check("post_rst_ready_dis", 64'(o_ready), 64'h0);
`ifdef DEMUX_1X2_DROP_CNT_EN
        check("post_rst_drop_cnt", 64'(o_drop_cnt), 64'h0);
`endif
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        model_clear();
        for (int n = 0; n < 3000; n++) begin
            i_valid    = 1'($urandom);
            i_en       = ($urandom_range(0, 7) != 0);
            i_cmd      = 2'($urandom);
            i_data_bus = $urandom;
            i_ready    = 2'($urandom);
            #4;
            exp_rdy = model_ready(i_en, i_cmd, i_ready);
            check("rnd_ready", 64'(o_ready), 64'(exp_rdy));
            check("rnd_valid", 64'(o_valid), 64'({m_full[1], m_full[0]}));
            check("rnd_lo", 64'(o_data_bus[DW-1:0]), 64'(m_word[0]));
            check("rnd_hi", 64'(o_data_bus[2*DW-1:DW]), 64'(m_word[1]));
`ifdef DEMUX_1X2_DROP_CNT_EN
            check("rnd_drop_cnt", 64'(o_drop_cnt), 64'(m_drops));
`endif
            acc = i_valid && exp_rdy;
            @(posedge clk);
            model_clock(acc, i_cmd, i_data_bus, i_ready);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
